// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants, decoded-entry struct and decode-stage state encoding.
// Shared by mips_field_decode and mips_decode_stage.
package mips_isa_pkg;

  localparam int unsigned OpcodeHi = 31;
  localparam int unsigned OpcodeLo = 26;
  localparam int unsigned RsHi     = 25;
  localparam int unsigned RsLo     = 21;
  localparam int unsigned RtHi     = 20;
  localparam int unsigned RtLo     = 16;
  localparam int unsigned RdHi     = 15;
  localparam int unsigned RdLo     = 11;
  localparam int unsigned ShiftHi  = 10;
  localparam int unsigned ShiftLo  = 6;
  localparam int unsigned FunctHi  = 5;
  localparam int unsigned ImmHi    = 15;
  localparam int unsigned JaddrHi  = 25;

  // Entries carry PC and extended immediate at a fixed maximum width; the stage slices them.
  localparam int unsigned PcMaxW  = 64;
  localparam int unsigned ExtMaxW = 64;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  typedef enum logic [1:0] {
    FmtR = 2'd0,
    FmtI = 2'd1,
    FmtJ = 2'd2
  } fmt_e;

  typedef struct packed {
    logic [5:0]         opcode;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         shift;
    logic [5:0]         funct;
    logic [15:0]        immediate;
    logic [25:0]        jaddr;
    logic [ExtMaxW-1:0] imm_ext;
    fmt_e               fmt;
    logic [PcMaxW-1:0]  pc;
    logic               illegal;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OpAndi) || (op == OpOri) || (op == OpXori) || (op == OpLui);
  endfunction

endpackage

// File: rtl/mips_decode_stage_if.sv
// Handshake and decoded-field bundle between an instruction source/sink and mips_decode_stage.
// master = environment side, slave = decode stage.
interface mips_decode_stage_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned EXT_W   = 32
) ();

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    pc_in;
  logic               out_valid;
  logic               out_ready;
  logic [5:0]         opcode;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic [4:0]         shift;
  logic [5:0]         funct;
  logic [15:0]        immediate;
  logic [25:0]        jaddr;
  logic [EXT_W-1:0]   imm_ext;
  logic [1:0]         fmt;
  logic [PC_W-1:0]    pc_out;
  logic               illegal;

  modport master (
    output flush, in_valid, instruction, pc_in, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, rd, shift, funct, immediate, jaddr,
    input  imm_ext, fmt, pc_out, illegal
  );

  modport slave (
    input  flush, in_valid, instruction, pc_in, out_ready,
    output in_ready, out_valid, opcode, rs, rt, rd, shift, funct, immediate, jaddr,
    output imm_ext, fmt, pc_out, illegal
  );

endinterface

// File: rtl/mips_field_decode.sv
// Combinational instruction word -> decoded entry. Opcode/funct legality check is built only
// when MIPS_DECODE_ILLEGAL_CHECK_EN is defined; otherwise illegal is constant 0.
module mips_field_decode
  import mips_isa_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32
) (
  input  logic [INSTR_W-1:0] instruction,
  input  logic [PC_W-1:0]    pc,
  output entry_t             entry
);

  logic [15:0] imm;
  assign imm = instruction[ImmHi:0];

  always_comb begin
    entry           = '0;
    entry.opcode    = instruction[OpcodeHi:OpcodeLo];
    entry.rs        = instruction[RsHi:RsLo];
    entry.rt        = instruction[RtHi:RtLo];
    entry.rd        = instruction[RdHi:RdLo];
    entry.shift     = instruction[ShiftHi:ShiftLo];
    entry.funct     = instruction[FunctHi:0];
    entry.immediate = imm;
    entry.jaddr     = instruction[JaddrHi:0];
    entry.imm_ext   = is_zero_ext(entry.opcode) ? {{(ExtMaxW-16){1'b0}}, imm}
                                                : {{(ExtMaxW-16){imm[15]}}, imm};
    if (entry.opcode == OpSpecial) begin
      entry.fmt = FmtR;
    end else if ((entry.opcode == OpJ) || (entry.opcode == OpJal)) begin
      entry.fmt = FmtJ;
    end else begin
      entry.fmt = FmtI;
    end
    entry.pc[PC_W-1:0] = pc;
`ifdef MIPS_DECODE_ILLEGAL_CHECK_EN
    if (entry.opcode == OpSpecial) begin
      entry.illegal = !(entry.funct inside {FnSll, FnSrl, FnSra, FnJr, [FnAdd:FnNor],
                                            FnSlt, FnSltu});
    end else begin
      entry.illegal = !(entry.opcode inside {[OpJ:OpLui], OpLb, OpLw, OpLbu, OpLhu,
                                             OpSb, OpSh, OpSw});
    end
`else
    entry.illegal = 1'b0;
`endif
  end

  // Bits above the fixed 32-bit layout carry no fields.
  if (INSTR_W > 32) begin : g_wide
    logic unused_instr_hi;
    assign unused_instr_hi = ^instruction[INSTR_W-1:32];
  end

endmodule

// File: rtl/mips_decode_stage.sv
// Registered, flow-controlled MIPS decode stage with a two-entry skid buffer and flush.
// Optional opcode/funct legality check: define MIPS_DECODE_ILLEGAL_CHECK_EN.
module mips_decode_stage
  import mips_isa_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned EXT_W   = 32
) (
  input logic                 clock,
  input logic                 reset_n,
  mips_decode_stage_if.slave  bus
);

  state_e state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  entry_t dec;
  logic   accept, take;

  mips_field_decode #(
    .INSTR_W(INSTR_W),
    .PC_W   (PC_W)
  ) u_field_decode (
    .instruction(bus.instruction),
    .pc         (bus.pc_in),
    .entry      (dec)
  );

  assign bus.in_ready  = (state_q != StFull);
  assign bus.out_valid = (state_q != StEmpty);
  assign accept        = bus.in_valid && bus.in_ready;
  assign take          = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            out_d   = dec;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && take) begin
            out_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = StFull;
          end else if (take) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (take) begin
            out_d   = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.opcode    = out_q.opcode;
  assign bus.rs        = out_q.rs;
  assign bus.rt        = out_q.rt;
  assign bus.rd        = out_q.rd;
  assign bus.shift     = out_q.shift;
  assign bus.funct     = out_q.funct;
  assign bus.immediate = out_q.immediate;
  assign bus.jaddr     = out_q.jaddr;
  assign bus.imm_ext   = out_q.imm_ext[EXT_W-1:0];
  assign bus.fmt       = out_q.fmt;
  assign bus.pc_out    = out_q.pc[PC_W-1:0];
  assign bus.illegal   = out_q.illegal;

  // Entry widths exceed the configured ones; the surplus bits are never presented.
  logic unused_entry_hi;
  assign unused_entry_hi = ^{out_q.pc, out_q.imm_ext};

endmodule

// File: tb/tb_mips_decode_stage.sv
// Self-checking bench for mips_decode_stage: directed test-plan cases plus randomized traffic
// checked against a queue-based reference of in-flight instructions.
module tb_mips_decode_stage;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  mips_decode_stage_if #(.INSTR_W(32), .PC_W(32), .EXT_W(32)) bus ();

  mips_decode_stage #(.INSTR_W(32), .PC_W(32), .EXT_W(32)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: words and PCs held by the stage, oldest first; capacity two.
  logic [31:0] wq[$];
  logic [31:0] pq[$];
  bit m_acc, m_tk;

  always @(posedge clock) begin
    if (!reset_n || bus.flush) begin
      wq.delete();
      pq.delete();
    end else begin
      m_acc = bus.in_valid && (wq.size() < 2);
      m_tk  = (wq.size() > 0) && bus.out_ready;
      if (m_tk) begin
        void'(wq.pop_front());
        void'(pq.pop_front());
      end
      if (m_acc) begin
        wq.push_back(bus.instruction);
        pq.push_back(bus.pc_in);
      end
    end
  end

  function automatic logic [31:0] exp_ext(input logic [31:0] w);
    logic [31:0] op, imm;
    op  = w >> 26;
    imm = w % 32'h10000;
    if (op >= 12 && op <= 15) return imm;
    if (imm >= 32'h8000) return imm + 32'hFFFF0000;
    return imm;
  endfunction

  function automatic logic [1:0] exp_fmt(input logic [31:0] w);
    logic [31:0] op;
    op = w >> 26;
    if (op == 0) return 2'd0;
    if (op == 2 || op == 3) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
`ifdef MIPS_DECODE_ILLEGAL_CHECK_EN
    logic [31:0] op, fn;
    op = w >> 26;
    fn = w % 64;
    if (op == 0)
      return !(fn == 0 || fn == 2 || fn == 3 || fn == 8 || (fn >= 32 && fn <= 39) ||
               fn == 42 || fn == 43);
    return !((op >= 2 && op <= 15) || op == 32 || op == 35 || op == 36 || op == 37 ||
             op == 40 || op == 41 || op == 43);
`else
    return 1'b0 & w[0];
`endif
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p,
                       input logic ordy, input logic fl);
    bus.in_valid    = v;
    bus.instruction = w;
    bus.pc_in       = p;
    bus.out_ready   = ordy;
    bus.flush       = fl;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 32'h2108FFFC, 32'h0000_0040, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0 1",
               bus.out_valid, bus.in_ready);
    end
    checks++;
    if ({bus.opcode, bus.rs, bus.rt, bus.rd, bus.shift, bus.funct} !== 32'h0 ||
        bus.imm_ext !== 32'h0 || bus.pc_out !== 32'h0 || bus.fmt !== 2'd0 ||
        bus.illegal !== 1'b0 || bus.jaddr !== 26'h0 || bus.immediate !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: op=%h imm_ext=%h pc=%h fmt=%0d ill=%b required all 0",
               bus.opcode, bus.imm_ext, bus.pc_out, bus.fmt, bus.illegal);
    end
  endtask

  task automatic test_stream();
    @(negedge clock) drive(1'b1, 32'h012A4020, 32'h100, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.opcode !== 6'd0 || bus.rs !== 5'd9 ||
        bus.rt !== 5'd10 || bus.rd !== 5'd8 || bus.funct !== 6'h20 || bus.fmt !== 2'd0 ||
        bus.pc_out !== 32'h100) begin
      errors++;
      $display("FAIL add_fields: v=%b op=%h rs=%0d rt=%0d rd=%0d fn=%h fmt=%0d pc=%h required 1 0 9 10 8 20 0 100",
               bus.out_valid, bus.opcode, bus.rs, bus.rt, bus.rd, bus.funct, bus.fmt,
               bus.pc_out);
    end
    drive(1'b1, 32'h2108FFFC, 32'h104, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.imm_ext !== 32'hFFFFFFFC || bus.fmt !== 2'd1 || bus.pc_out !== 32'h104) begin
      errors++;
      $display("FAIL addi_sext: imm_ext=%h fmt=%0d pc=%h required FFFFFFFC 1 104",
               bus.imm_ext, bus.fmt, bus.pc_out);
    end
    drive(1'b1, 32'h3508FFFC, 32'h108, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.imm_ext !== 32'h0000FFFC || bus.fmt !== 2'd1) begin
      errors++;
      $display("FAIL ori_zext: imm_ext=%h fmt=%0d required 0000FFFC 1", bus.imm_ext, bus.fmt);
    end
    drive(1'b1, 32'h08100004, 32'h10C, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.fmt !== 2'd2 || bus.jaddr !== 26'h0100004 || bus.opcode !== 6'h02) begin
      errors++;
      $display("FAIL jump: fmt=%0d jaddr=%h op=%h required 2 0100004 02",
               bus.fmt, bus.jaddr, bus.opcode);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock) drive(1'b1, 32'h8D090010, 32'h200, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_one: in_ready=%b required 1", bus.in_ready);
    end
    drive(1'b1, 32'h3C01ABCD, 32'h204, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_full: in_ready=%b required 0", bus.in_ready);
    end
    drive(1'b1, 32'h00851022, 32'h208, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h200 || bus.opcode !== 6'h23 ||
        bus.imm_ext !== 32'h10 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: v=%b pc=%h op=%h imm_ext=%h rdy=%b required 1 200 23 10 0",
               bus.out_valid, bus.pc_out, bus.opcode, bus.imm_ext, bus.in_ready);
    end
    drive(1'b1, 32'h00851022, 32'h208, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.pc_out !== 32'h204 || bus.imm_ext !== 32'h0000ABCD || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: pc=%h imm_ext=%h rdy=%b required 204 0000ABCD 1",
               bus.pc_out, bus.imm_ext, bus.in_ready);
    end
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h208 || bus.funct !== 6'h22) begin
      errors++;
      $display("FAIL bp_third: v=%b pc=%h fn=%h required 1 208 22",
               bus.out_valid, bus.pc_out, bus.funct);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clock) drive(1'b1, 32'h2108FFFC, 32'h300, 1'b0, 1'b0);
    @(negedge clock) drive(1'b1, 32'h3508FFFC, 32'h304, 1'b0, 1'b0);
    @(negedge clock) drive(1'b1, 32'h08100004, 32'h308, 1'b0, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle_ready: in_ready=%b out_valid=%b required 0 1",
               bus.in_ready, bus.out_valid);
    end
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: out_valid=%b in_ready=%b required 0 1",
               bus.out_valid, bus.in_ready);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_dropped[%0d]: out_valid=%b pc=%h required 0",
                 i, bus.out_valid, bus.pc_out);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words[2];
    logic        req;
    words[0] = 32'hFC000000;
    words[1] = 32'h012A4020;
    for (int i = 0; i < 2; i++) begin
`ifdef MIPS_DECODE_ILLEGAL_CHECK_EN
      req = (i == 0);
`else
      req = 1'b0;
`endif
      @(negedge clock) drive(1'b1, words[i], 32'h400, 1'b1, 1'b0);
      @(negedge clock) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.illegal !== req) begin
        errors++;
        $display("FAIL illegal[%h]: v=%b illegal=%b required 1 %b",
                 words[i], bus.out_valid, bus.illegal, req);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [5:0]  ops[8];
    logic [31:0] w, p, ew;
    ops = '{6'h00, 6'h02, 6'h0C, 6'h0F, 6'h08, 6'h23, 6'h2B, 6'h3F};
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== (wq.size() != 0) || bus.in_ready !== (wq.size() < 2)) begin
        errors++;
        $display("FAIL rand_hs[%0d]: out_valid=%b in_ready=%b required %b %b", c,
                 bus.out_valid, bus.in_ready, wq.size() != 0, wq.size() < 2);
      end
      if (wq.size() != 0) begin
        ew = wq[0];
        checks++;
        if ({bus.opcode, bus.rs, bus.rt, bus.rd, bus.shift, bus.funct} !== ew ||
            bus.immediate !== ew[15:0] || bus.jaddr !== ew[25:0] ||
            bus.imm_ext !== exp_ext(ew) || bus.fmt !== exp_fmt(ew) ||
            bus.pc_out !== pq[0] || bus.illegal !== exp_illegal(ew)) begin
          errors++;
          $display("FAIL rand_entry[%0d]: word=%h imm_ext=%h fmt=%0d pc=%h ill=%b required %h %h %0d %h %b",
                   c, {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shift, bus.funct}, bus.imm_ext,
                   bus.fmt, bus.pc_out, bus.illegal, ew, exp_ext(ew), exp_fmt(ew), pq[0],
                   exp_illegal(ew));
        end
      end
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w[31:26] = ops[$urandom_range(7, 0)];
      p = $urandom;
      drive(1'($urandom_range(3, 0) != 0), w, p, 1'($urandom_range(2, 0) != 0),
            1'($urandom_range(19, 0) == 0));
    end
    @(negedge clock) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clock) drive(1'b1, 32'h2108FFFC, 32'h500, 1'b0, 1'b0);
    @(negedge clock) drive(1'b1, 32'h3508FFFC, 32'h504, 1'b0, 1'b1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pc_out !== 32'h0 ||
        bus.imm_ext !== 32'h0 || bus.fmt !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: v=%b rdy=%b pc=%h imm_ext=%h fmt=%0d required 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.pc_out, bus.imm_ext, bus.fmt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_decode_stage.md
# mips_decode_stage

Registered, flow-controlled instruction decode stage for the MIPS core, replacing the purely combinational field splitter on the path to a pipelined datapath. It accepts a fetched instruction word and PC through a valid/ready handshake, splits the word into all R/I/J fields, produces an extended immediate and format class, and presents them one cycle later. A two-entry skid buffer keeps full throughput under back-pressure, and a flush input discards in-flight work on branch redirect.

## Interface
- `INSTR_W`, 32: instruction width; fixed field layout, must be ≥ 32.
- `PC_W`, 32: PC width carried alongside the instruction.
- `EXT_W`, 32: width of the extended immediate, ≥ 16.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `flush` in 1: drop all buffered entries.
- `in_valid` in 1 / `in_ready` out 1: upstream handshake.
- `instruction` in INSTR_W: fetched word.
- `pc_in` in PC_W: PC of `instruction`.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `opcode` out 6 [31:26]; `rs` out 5 [25:21]; `rt` out 5 [20:16]; `rd` out 5 [15:11]; `shift` out 5 [10:6]; `funct` out 6 [5:0]; `immediate` out 16 [15:0]; `jaddr` out 26 [25:0].
- `imm_ext` out EXT_W: extended immediate.
- `fmt` out 2: 0 = R (opcode 0), 2 = J (opcode 0x02/0x03), 1 = I (others).
- `pc_out` out PC_W: PC of the presented instruction.
- `illegal` out 1: see Configuration.

## Operation
- Transfer occurs on an edge where valid && ready.
- Extension: zero-extend for opcodes 0x0C andi, 0x0D ori, 0x0E xori, and 0x0F lui, which uses zero-extension to EXT_W; sign-extend `immediate[15]` for all others.
- Decode is computed from the input word and stored in the entry; outputs come only from registers.
- States: EMPTY, ONE, which holds the output register, and FULL, which holds the output register plus the skid entry.
  - EMPTY → ONE on input accept.
  - ONE stays on accept plus output take, with the new entry going to the output register.
  - ONE → EMPTY on output take with no accept.
  - ONE → FULL on accept without take, with the new entry going to skid.
  - FULL → ONE on take, with skid moving to the output register.
- `in_ready` = state != FULL; it depends on registered state only.
- `out_valid` = state != EMPTY.
- Entry fields are held stable while out_valid && !out_ready.
- `flush`: the next state is EMPTY regardless of handshakes. An input offered in the flush cycle is dropped, and `in_ready` stays as registered in that cycle.
- Reset (`reset_n` low at an edge): state EMPTY, and every data output, `fmt`, and `illegal` is 0. Reset mid-stream drops all entries. Reset overrides flush.

## Timing
- Latency: accept at edge N → `out_valid` high after edge N, so fields are visible in cycle N+1.
- Throughput is 1 per cycle with `out_ready` held high.
- After `out_ready` drops, at most one further input is accepted; `in_ready` falls the cycle after FULL is entered.
- No combinational path from `out_ready` to `in_ready`, or from `instruction` to any output.

## Configuration
- `MIPS_DECODE_ILLEGAL_CHECK_EN` defined:
  - `illegal` = 1 for an entry whose opcode is outside {0x00, 0x02–0x0F, 0x20, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B}.
  - `illegal` = 1 for opcode 0 with funct outside {0x00, 0x02, 0x03, 0x08, 0x20–0x27, 0x2A, 0x2B}.
  - `illegal` is registered with the entry.
- `MIPS_DECODE_ILLEGAL_CHECK_EN` undefined: `illegal` is tied to 0 and no check logic is built.

## Structure
- Package `mips_isa_pkg` holds:
  - field bit positions;
  - opcode/funct constants;
  - the `fmt` enum (R, I, J);
  - the decoded-entry struct (fields, `imm_ext`, `fmt`, `pc`, `illegal`);
  - the state enum.
- Sub-module `mips_field_decode`: combinational word → entry struct. The stage instantiates it once on the input side.

## Test plan
- Reset then stream: feed 0x012A4020 (add $t0,$t1,$t2), `out_ready`=1.
  - Next cycle: `opcode`=0, `rs`=9, `rt`=10, `rd`=8, `funct`=0x20, `fmt`=0.
- Extension: 0x2108FFFC (addi) → `imm_ext`=0xFFFFFFFC, `fmt`=1.
  - 0x3508FFFC (ori) → `imm_ext`=0x0000FFFC.
- Jump: 0x08100004 → `fmt`=2, `jaddr`=0x0100004.
- Back-pressure: `out_ready`=0 while three words are offered back to back.
  - Two are accepted and `in_ready` drops.
  - Outputs hold the first word.
  - On release the words emerge in order with no loss or duplication.
- Flush in FULL: next cycle `out_valid`=0 and `in_ready`=1; the word offered during the flush cycle never appears.
- With the macro defined, 0xFC000000 → `illegal`=1 and 0x012A4020 → `illegal`=0. Without the macro, both give `illegal`=0.
